// File: rtl/parse_sampler.sv
// -----------------------------------------------------------------------------
// parse_sampler
//
// Rejection sampler that turns a squeezed XOF byte stream into polynomial
// coefficients. Words from the keccak output FIFO are appended to an 88-bit
// bit buffer, consumed LSB-first in 3-byte groups. Each group yields two
// 12-bit candidates, d1 and d2. A candidate is emitted only if it is below Q.
// The sampler stops after N coefficients have been handed off downstream.
//
// Parameters
//   Q            rejection bound (a candidate is accepted iff it is < Q)
//   N            coefficients per polynomial
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst          asynchronous, active-high reset
//   start        one-cycle pulse that begins a new polynomial from any state
//   in_word      64-bit XOF word presented by the keccak FIFO
//   in_ready     keccak FIFO is non-empty
//   gimme        FIFO read / squeeze request to keccak
//   coeff        accepted coefficient
//   coeff_idx    index of coeff within the polynomial (0..N-1)
//   coeff_valid  coeff/coeff_idx valid; held until coeff_ready
//   coeff_ready  downstream accepts coeff when high together with coeff_valid
//   done         N coefficients delivered; held until the next start
//   rej_cnt      (only with PARSE_STATS_EN) rejected candidates since start,
//                saturating at 0xFFFF
//
// Build option
//   PARSE_STATS_EN  adds the rej_cnt output and its counter.
// -----------------------------------------------------------------------------
module parse_sampler #(
    parameter int Q = 3329,
    parameter int N = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] in_word,
    input  logic        in_ready,
    output logic        gimme,
    output logic [11:0] coeff,
    output logic [7:0]  coeff_idx,
    output logic        coeff_valid,
    input  logic        coeff_ready,
    output logic        done
`ifdef PARSE_STATS_EN
    ,
    output logic [15:0] rej_cnt
`endif
);

    localparam logic [11:0] Q_BOUND  = 12'(Q);
    localparam logic [7:0]  LAST_IDX = 8'(N - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        EMIT1 = 3'd2,
        EMIT2 = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Candidate acceptance rule.
    function automatic logic accepted(input logic [11:0] cand);
        return (cand < Q_BOUND);
    endfunction

    state_t      state;
    state_t      state_next;
    logic [87:0] bitbuf;
    logic [87:0] bitbuf_next;
    logic [6:0]  count;
    logic [6:0]  count_next;
    logic        pending;
    logic        pending_next;
    logic [11:0] d2;
    logic [11:0] d2_next;
    logic [11:0] coeff_next;
    logic [7:0]  coeff_idx_next;
    logic        coeff_valid_next;
    logic        done_next;
    logic        gimme_next;

    // Next-state, buffer and output computation.
    always_comb begin
        state_next       = state;
        bitbuf_next      = bitbuf;
        count_next       = count;
        pending_next     = pending;
        d2_next          = d2;
        coeff_next       = coeff;
        coeff_idx_next   = coeff_idx;
        coeff_valid_next = coeff_valid;
        done_next        = done;

        if (start) begin
            state_next       = FILL;
            bitbuf_next      = 88'd0;
            count_next       = 7'd0;
            pending_next     = 1'b0;
            coeff_idx_next   = 8'd0;
            coeff_valid_next = 1'b0;
            done_next        = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                FILL: begin
                    if (pending) begin
                        // The FIFO presents the word one cycle after the read;
                        // new bits land directly above the bits still buffered.
                        bitbuf_next  = bitbuf | ({24'd0, in_word} << count);
                        count_next   = count + 7'd64;
                        pending_next = 1'b0;
                    end else if (count >= 7'd24) begin
                        // Bottom 24 bits are b0,b1,b2: d1 = b1[3:0]:b0, d2 = b2:b1[7:4].
                        d2_next     = bitbuf[23:12];
                        bitbuf_next = bitbuf >> 7'd24;
                        count_next  = count - 7'd24;
                        state_next  = EMIT1;
                        if (accepted(bitbuf[11:0])) begin
                            coeff_next       = bitbuf[11:0];
                            coeff_valid_next = 1'b1;
                        end else begin
                            coeff_valid_next = 1'b0;
                        end
                    end else begin
                        // gimme is high here; an empty FIFO makes it a squeeze only.
                        pending_next = gimme & in_ready;
                    end
                end
                EMIT1: begin
                    if (coeff_valid && !coeff_ready) begin
                        state_next = EMIT1;
                    end else if (coeff_valid && (coeff_idx == LAST_IDX)) begin
                        // Final coefficient taken: d2 is dropped.
                        state_next       = DONE;
                        coeff_valid_next = 1'b0;
                        done_next        = 1'b1;
                    end else begin
                        if (coeff_valid) begin
                            coeff_idx_next = coeff_idx + 8'd1;
                        end else begin
                            coeff_idx_next = coeff_idx;
                        end
                        state_next = EMIT2;
                        if (accepted(d2)) begin
                            coeff_next       = d2;
                            coeff_valid_next = 1'b1;
                        end else begin
                            coeff_valid_next = 1'b0;
                        end
                    end
                end
                EMIT2: begin
                    if (coeff_valid && !coeff_ready) begin
                        state_next = EMIT2;
                    end else if (coeff_valid && (coeff_idx == LAST_IDX)) begin
                        state_next       = DONE;
                        coeff_valid_next = 1'b0;
                        done_next        = 1'b1;
                    end else begin
                        if (coeff_valid) begin
                            coeff_idx_next = coeff_idx + 8'd1;
                        end else begin
                            coeff_idx_next = coeff_idx;
                        end
                        coeff_valid_next = 1'b0;
                        state_next       = FILL;
                    end
                end
                DONE: begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end
                default: begin
                    state_next       = IDLE;
                    coeff_valid_next = 1'b0;
                    done_next        = 1'b0;
                end
            endcase
        end

        // Registered request: raised whenever the next cycle is a FILL cycle
        // that still lacks a full group and has no read in flight.
        gimme_next = (state_next == FILL) && (count_next < 7'd24) && !pending_next;
    end

    // State, buffer and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bitbuf      <= 88'd0;
            count       <= 7'd0;
            pending     <= 1'b0;
            d2          <= 12'd0;
            gimme       <= 1'b0;
            coeff       <= 12'd0;
            coeff_idx   <= 8'd0;
            coeff_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            bitbuf      <= bitbuf_next;
            count       <= count_next;
            pending     <= pending_next;
            d2          <= d2_next;
            gimme       <= gimme_next;
            coeff       <= coeff_next;
            coeff_idx   <= coeff_idx_next;
            coeff_valid <= coeff_valid_next;
            done        <= done_next;
        end
    end

`ifdef PARSE_STATS_EN
    // An EMIT cycle with coeff_valid low means the candidate just evaluated
    // was rejected (a rejected candidate spends exactly one cycle there).
    logic reject_evt;
    assign reject_evt = ((state == EMIT1) || (state == EMIT2)) && !coeff_valid;

    // Saturating rejection counter, cleared by start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rej_cnt <= 16'd0;
        end else if (start) begin
            rej_cnt <= 16'd0;
        end else if (reject_evt && (rej_cnt != 16'hFFFF)) begin
            rej_cnt <= rej_cnt + 16'd1;
        end else begin
            rej_cnt <= rej_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_parse_sampler.sv
// -----------------------------------------------------------------------------
// tb_parse_sampler
//
// Scoreboard bench for parse_sampler. Words pushed into a modelled keccak FIFO
// are also run through a software Parse model, which queues the expected
// (index, value) pairs. A monitor pops and compares on every handshake.
// -----------------------------------------------------------------------------
module tb_parse_sampler;

    localparam int Q = 3329;
    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] in_word;
    logic        in_ready;
    logic        gimme;
    logic [11:0] coeff;
    logic [7:0]  coeff_idx;
    logic        coeff_valid;
    logic        coeff_ready;
    logic        done;
`ifdef PARSE_STATS_EN
    logic [15:0] rej_cnt;
`endif

    always #5 clk = ~clk;

    parse_sampler #(.Q(Q), .N(N)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .in_word(in_word),
        .in_ready(in_ready),
        .gimme(gimme),
        .coeff(coeff),
        .coeff_idx(coeff_idx),
        .coeff_valid(coeff_valid),
        .coeff_ready(coeff_ready),
        .done(done)
`ifdef PARSE_STATS_EN
        ,
        .rej_cnt(rej_cnt)
`endif
    );

    typedef struct packed {
        logic [7:0]  idx;
        logic [11:0] val;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] fifo[$];
    int          byteq[$];
    exp_t        expq[$];
    int          produced = 0;
    int          model_rej = 0;
    int          rdy_pct = 100;
    int          inr_pct = 100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Software Parse over the byte stream, in FIFO order.
    task automatic push_word(input logic [63:0] w);
        int b0, b1, b2;
        int cand[2];
        fifo.push_back(w);
        for (int b = 0; b < 8; b++) byteq.push_back(int'(w[8*b +: 8]));
        while (byteq.size() >= 3 && produced < N) begin
            b0 = byteq.pop_front();
            b1 = byteq.pop_front();
            b2 = byteq.pop_front();
            cand[0] = b0 + 256 * (b1 % 16);
            cand[1] = (b1 / 16) + 16 * b2;
            for (int k = 0; k < 2; k++) begin
                if (produced < N) begin
                    if (cand[k] < Q) begin
                        expq.push_back(exp_t'{idx: 8'(produced), val: 12'(cand[k])});
                        produced++;
                    end else begin
                        model_rej++;
                    end
                end
            end
        end
    endtask

    task automatic push_random(input int n);
        for (int i = 0; i < n; i++) push_word({$urandom(), $urandom()});
    endtask

    // Fresh FIFO and model, start pulse, then check that gimme repeats on empty.
    task automatic begin_poly();
        @(posedge clk);
        #2;
        fifo.delete();
        byteq.delete();
        expq.delete();
        produced  = 0;
        model_rej = 0;
        start     = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("gimme_repeat_on_empty", gimme, 1'b1);
            check("no_done_after_start", done, 1'b0);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", done, 1'b1);
        check("all_expected_seen", 64'(expq.size()), 64'd0);
`ifdef PARSE_STATS_EN
        check("rej_cnt_at_done", rej_cnt, 64'(model_rej));
`endif
    endtask

    // FIFO / downstream driver: pops after a granted read, randomizes stalls.
    initial begin
        logic g;
        in_word     = 64'd0;
        in_ready    = 1'b0;
        coeff_ready = 1'b0;
        forever begin
            @(negedge clk);
            g = gimme && in_ready;
            @(posedge clk);
            #1;
            if (g && fifo.size() > 0) in_word = fifo.pop_front();
            in_ready    = (fifo.size() > 0) && ($urandom_range(99) < 32'(inr_pct));
            coeff_ready = ($urandom_range(99) < 32'(rdy_pct));
        end
    end

    // Monitor: handshake scoreboard, hold stability, done after last index.
    logic        hold_chk = 1'b0;
    logic [11:0] held_c;
    logic [7:0]  held_i;
    logic        expect_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (hold_chk && coeff_valid) begin
            check("hold_coeff", coeff, held_c);
            check("hold_idx", coeff_idx, held_i);
        end
        hold_chk = coeff_valid && !coeff_ready;
        held_c   = coeff;
        held_i   = coeff_idx;
        if (expect_done) begin
            check("done_after_last", done, 1'b1);
            expect_done = 1'b0;
        end
        if (coeff_valid) check("no_gimme_while_valid", gimme, 1'b0);
        if (coeff_valid && coeff_ready) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_coeff: got %0d idx %0d, expected no output", coeff, coeff_idx);
            end else begin
                e = expq.pop_front();
                check("coeff_val", coeff, e.val);
                check("coeff_idx", coeff_idx, e.idx);
                if (int'(e.idx) == N - 1) expect_done = 1'b1;
            end
        end
    end

    // Watchdog.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] w;
        logic [11:0] c0;
        logic [7:0]  i0;
        int          n;
        int          vseen;
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gimme", gimme, 1'b0);
        check("rst_coeff", coeff, 12'd0);
        check("rst_idx", coeff_idx, 8'd0);
        check("rst_valid", coeff_valid, 1'b0);
        check("rst_done", done, 1'b0);
`ifdef PARSE_STATS_EN
        check("rst_rej_cnt", rej_cnt, 16'd0);
`endif
        @(posedge clk);
        #2;
        rst = 1'b0;

        // First word 0x030201 -> 513, 48; no stalls.
        rdy_pct = 100;
        inr_pct = 100;
        begin_poly();
        w = {$urandom(), $urandom()};
        w[23:0] = 24'h030201;
        push_word(w);
        push_random(80);
        wait_done();
        repeat (5) @(negedge clk);
        check("done_held", done, 1'b1);
        check("gimme_low_in_done", gimme, 1'b0);
        check("valid_low_in_done", coeff_valid, 1'b0);

        // Boundary candidates 3328 (accepted) and 3329 (rejected), with stalls.
        rdy_pct = 60;
        inr_pct = 70;
        begin_poly();
        w = {$urandom(), $urandom()};
        w[47:0] = 48'h000D01_000D00;
        push_word(w);
        push_random(80);
        wait_done();

        // All-ones stream: every candidate rejected.
        rdy_pct = 100;
        inr_pct = 100;
        begin_poly();
        for (int i = 0; i < 10; i++) push_word(64'hFFFF_FFFF_FFFF_FFFF);
        vseen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (coeff_valid) vseen++;
        end
        check("ff_no_valid", 64'(vseen), 64'd0);
        check("ff_done_low", done, 1'b0);
        check("ff_gimme_refill", gimme, 1'b1);
`ifdef PARSE_STATS_EN
        check("ff_rej_cnt", rej_cnt, 64'(model_rej));
`endif

        // Downstream stalled for 5 cycles while a coefficient is valid.
        rdy_pct = 0;
        inr_pct = 100;
        begin_poly();
        push_random(80);
        n = 0;
        while (!coeff_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall_valid_seen", coeff_valid, 1'b1);
        c0 = coeff;
        i0 = coeff_idx;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_coeff", coeff, c0);
            check("stall_idx", coeff_idx, i0);
            check("stall_gimme", gimme, 1'b0);
        end
        rdy_pct = 100;
        wait_done();

        // Random streams with random stalls.
        for (int p = 0; p < 2; p++) begin
            rdy_pct = 30 + 30 * p;
            inr_pct = 50 + 30 * p;
            begin_poly();
            push_random(80);
            wait_done();
        end

        // Reset in the middle of a polynomial.
        rdy_pct = 80;
        inr_pct = 80;
        begin_poly();
        push_random(80);
        n = 0;
        while (coeff_idx != 8'd100 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reached_idx_100", coeff_idx, 8'd100);
        rst = 1'b1;
        #1;
        check("midrst_gimme", gimme, 1'b0);
        check("midrst_coeff", coeff, 12'd0);
        check("midrst_idx", coeff_idx, 8'd0);
        check("midrst_valid", coeff_valid, 1'b0);
        check("midrst_done", done, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        expq.delete();
        vseen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (coeff_valid || gimme || done) vseen++;
        end
        check("idle_after_rst", 64'(vseen), 64'd0);
        begin_poly();
        push_random(80);
        wait_done();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
